// File: rtl/dds_ramp_gen.sv
// dds_ramp_gen: burst-sequenced sawtooth/triangle ramp generator for the
// TDLAS laser-current drive. A phase accumulator runs inside an
// IDLE/DELAY/RAMP/DONE sequencer. Its sample is scaled by an amplitude word
// and offset in a two-stage pipeline. A live DC level is output between ramps.
module dds_ramp_gen #(
    parameter int PHASE_W = 32,
    parameter int WAVE_W  = 16,
    parameter int AMP_W   = 16,
    parameter int OUT_W   = 32
) (
    input  logic               clk_dds,
    input  logic               rst,
    input  logic               out_en,
    input  logic [1:0]         mode,
    input  logic [PHASE_W-1:0] phase_max,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [31:0]        delay_cnt,
    input  logic [15:0]        burst_len,
    input  logic [AMP_W-1:0]   amp,
    input  logic [OUT_W-1:0]   dc_hold,
    input  logic [OUT_W-1:0]   dc_offset,
    output logic [OUT_W-1:0]   wave_out,
    output logic               ramp_active,
    output logic               ramp_start,
    output logic               burst_done,
    output logic               busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_RAMP, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [31:0]        dly_q, dly_d;
    logic [15:0]        ramp_cnt_q, ramp_cnt_d;
    logic               first_q, first_d;

    logic [1:0]         mode_s_q, mode_s_d;
    logic [PHASE_W-1:0] phase_max_s_q, phase_max_s_d;
    logic [PHASE_W-1:0] freq_s_q, freq_s_d;
    logic [31:0]        delay_s_q, delay_s_d;
    logic [15:0]        burst_s_q, burst_s_d;
    logic [AMP_W-1:0]   amp_s_q, amp_s_d;
    logic [OUT_W-1:0]   offset_s_q, offset_s_d;

    logic [WAVE_W-1:0]  w1_q, w1_d;
    logic               act1_q, act1_d;
    logic               start1_q, start1_d;
    logic               done1_q, done1_d;
    logic [AMP_W-1:0]   amp1_q, amp1_d;
    logic [OUT_W-1:0]   off1_q, off1_d;

    logic [OUT_W-1:0]   wave_q, wave_d;
    logic               active_q, active_d;
    logic               start_q, start_d;
    logic               done_q, done_d;

    logic [PHASE_W:0]   sum;
    logic [15:0]        ramp_cnt_inc;
    logic               load_shadow;
    logic [WAVE_W-1:0]  tri_t;
    logic [WAVE_W+AMP_W-1:0] prod;
    logic [OUT_W-1:0]   prod_ext;

    // Sequencer: next state, phase accumulation, delay and ramp counting
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        dly_d        = dly_q;
        ramp_cnt_d   = ramp_cnt_q;
        first_d      = 1'b0;
        load_shadow  = 1'b0;
        sum          = {1'b0, phase_q} + {1'b0, freq_s_q};
        ramp_cnt_inc = ramp_cnt_q + 16'd1;
        if (!out_en) begin
            state_d    = ST_IDLE;
            phase_d    = '0;
            dly_d      = '0;
            ramp_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_DELAY;
                    phase_d     = '0;
                    dly_d       = '0;
                    ramp_cnt_d  = '0;
                    load_shadow = 1'b1;
                end
                ST_DELAY: begin
                    if (dly_q == delay_s_q) begin
                        state_d = ST_RAMP;
                        phase_d = '0;
                        dly_d   = '0;
                        first_d = 1'b1;
                    end else begin
                        dly_d = dly_q + 32'd1;
                    end
                end
                ST_RAMP: begin
                    if (sum >= {1'b0, phase_max_s_q}) begin
                        ramp_cnt_d = ramp_cnt_inc;
                        phase_d    = '0;
                        if (burst_s_q != 16'd0 && ramp_cnt_inc == burst_s_q) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d     = ST_DELAY;
                            dly_d       = '0;
                            load_shadow = 1'b1;
                        end
                    end else begin
                        phase_d = sum[PHASE_W-1:0];
                    end
                end
                default: begin
                    state_d = ST_DONE;
                end
            endcase
        end
    end

    // Shadow configuration captured on every entry to DELAY
    always_comb begin
        mode_s_d      = mode_s_q;
        phase_max_s_d = phase_max_s_q;
        freq_s_d      = freq_s_q;
        delay_s_d     = delay_s_q;
        burst_s_d     = burst_s_q;
        amp_s_d       = amp_s_q;
        offset_s_d    = offset_s_q;
        if (load_shadow) begin
            mode_s_d      = mode;
            phase_max_s_d = phase_max;
            freq_s_d      = freq_word;
            delay_s_d     = delay_cnt;
            burst_s_d     = burst_len;
            amp_s_d       = amp;
            offset_s_d    = dc_offset;
        end
    end

    // Stage 1: shape the phase into a sample; carry gain/offset with it
    always_comb begin
        tri_t = phase_q[PHASE_W-2 -: WAVE_W];
        case (mode_s_q)
            2'b01:   w1_d = ~phase_q[PHASE_W-1 -: WAVE_W];
            2'b10:   w1_d = phase_q[PHASE_W-1] ? ~tri_t : tri_t;
            default: w1_d = phase_q[PHASE_W-1 -: WAVE_W];
        endcase
        act1_d   = (state_q == ST_RAMP);
        start1_d = (state_q == ST_RAMP) && first_q;
        done1_d  = (state_q == ST_DONE);
        amp1_d   = amp_s_q;
        off1_d   = offset_s_q;
    end

    // Stage 2: scale and offset ramp samples, otherwise pass the live DC level
    always_comb begin
        prod     = {{AMP_W{1'b0}}, w1_q} * {{WAVE_W{1'b0}}, amp1_q};
        prod_ext = '0;
        prod_ext[WAVE_W+AMP_W-1:0] = prod;
        wave_d   = act1_q ? (prod_ext + off1_q) : dc_hold;
        active_d = act1_q;
        start_d  = start1_q;
        done_d   = done1_q && (state_q == ST_DONE);
    end

    // All registers, cleared together by synchronous reset
    always_ff @(posedge clk_dds) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            phase_q       <= '0;
            dly_q         <= '0;
            ramp_cnt_q    <= '0;
            first_q       <= 1'b0;
            mode_s_q      <= '0;
            phase_max_s_q <= '0;
            freq_s_q      <= '0;
            delay_s_q     <= '0;
            burst_s_q     <= '0;
            amp_s_q       <= '0;
            offset_s_q    <= '0;
            w1_q          <= '0;
            act1_q        <= 1'b0;
            start1_q      <= 1'b0;
            done1_q       <= 1'b0;
            amp1_q        <= '0;
            off1_q        <= '0;
            wave_q        <= '0;
            active_q      <= 1'b0;
            start_q       <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            dly_q         <= dly_d;
            ramp_cnt_q    <= ramp_cnt_d;
            first_q       <= first_d;
            mode_s_q      <= mode_s_d;
            phase_max_s_q <= phase_max_s_d;
            freq_s_q      <= freq_s_d;
            delay_s_q     <= delay_s_d;
            burst_s_q     <= burst_s_d;
            amp_s_q       <= amp_s_d;
            offset_s_q    <= offset_s_d;
            w1_q          <= w1_d;
            act1_q        <= act1_d;
            start1_q      <= start1_d;
            done1_q       <= done1_d;
            amp1_q        <= amp1_d;
            off1_q        <= off1_d;
            wave_q        <= wave_d;
            active_q      <= active_d;
            start_q       <= start_d;
            done_q        <= done_d;
        end
    end

    assign wave_out    = wave_q;
    assign ramp_active = active_q;
    assign ramp_start  = start_q;
    assign burst_done  = done_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dds_ramp_gen.sv
// Scoreboard bench for dds_ramp_gen with small test widths.
// Directed runs push hand-computed ramp samples into a queue.
// A monitor pops one sample each time ramp_active is seen.
module tb_dds_ramp_gen;

    logic        clk;
    logic        rst;
    logic        out_en;
    logic [1:0]  mode;
    logic [15:0] phase_max;
    logic [15:0] freq_word;
    logic [31:0] delay_cnt;
    logic [15:0] burst_len;
    logic [7:0]  amp;
    logic [15:0] dc_hold;
    logic [15:0] dc_offset;
    logic [15:0] wave_out;
    logic        ramp_active;
    logic        ramp_start;
    logic        burst_done;
    logic        busy;

    typedef struct {
        logic [15:0] wave;
        logic        start;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc;

    dds_ramp_gen #(.PHASE_W(16), .WAVE_W(8), .AMP_W(8), .OUT_W(16)) dut (
        .clk_dds    (clk),
        .rst        (rst),
        .out_en     (out_en),
        .mode       (mode),
        .phase_max  (phase_max),
        .freq_word  (freq_word),
        .delay_cnt  (delay_cnt),
        .burst_len  (burst_len),
        .amp        (amp),
        .dc_hold    (dc_hold),
        .dc_offset  (dc_offset),
        .wave_out   (wave_out),
        .ramp_active(ramp_active),
        .ramp_start (ramp_start),
        .burst_done (burst_done),
        .busy       (busy)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every ramp sample at the output must match the next queued one
    always @(negedge clk) begin
        if (ramp_active) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_sample: got wave=%h start=%b, queue empty",
                         wave_out, ramp_start);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (wave_out !== e.wave || ramp_start !== e.start) begin
                    errors++;
                    $display("[TB] FAIL ramp_sample: got wave=%h start=%b, expected wave=%h start=%b",
                             wave_out, ramp_start, e.wave, e.start);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic pushSample(input logic [15:0] w, input logic s);
        exp_t e;
        e.wave  = w;
        e.start = s;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [15:0] pmax,
                                 input logic [15:0] fw, input logic [31:0] dly,
                                 input logic [15:0] bl, input logic [7:0] a);
        @(negedge clk);
        mode      = m;
        phase_max = pmax;
        freq_word = fw;
        delay_cnt = dly;
        burst_len = bl;
        amp       = a;
        out_en    = 1'b1;
    endtask

    // Counts negedges until ramp_start is seen; 200-cycle bound
    task automatic waitStart(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!ramp_start && cycles < 200);
        if (!ramp_start) begin
            checks++;
            errors++;
            $display("[TB] FAIL start_timeout: got no ramp_start, expected one within 200 cycles");
        end
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!burst_done && n < 500);
        checkOutput("burst_done_seen", {31'd0, burst_done}, 32'd1);
        checkOutput("done_wave", {16'd0, wave_out}, {16'd0, dc_hold});
        checkOutput("done_inactive", {31'd0, ramp_active}, 32'd0);
    endtask

    task automatic stopRun();
        @(negedge clk);
        out_en = 1'b0;
        @(negedge clk);
        checkOutput("busy_low", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("done_cleared", {31'd0, burst_done}, 32'd0);
        checkOutput("idle_wave", {16'd0, wave_out}, {16'd0, dc_hold});
        checkOutput("queue_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        out_en    = 1'b0;
        mode      = 2'b00;
        phase_max = 16'h0000;
        freq_word = 16'h0000;
        delay_cnt = 32'd0;
        burst_len = 16'd0;
        amp       = 8'd0;
        dc_hold   = 16'h0055;
        dc_offset = 16'h0100;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_wave", {16'd0, wave_out}, 32'd0);
        checkOutput("rst_active", {31'd0, ramp_active}, 32'd0);
        checkOutput("rst_start", {31'd0, ramp_start}, 32'd0);
        checkOutput("rst_done", {31'd0, burst_done}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic saw up: 15 samples 0100..02C0 after four DELAY cycles
        for (int k = 0; k < 15; k++) pushSample(16'h0100 + 16'(k * 16'h20), k == 0);
        applyStimulus(2'b00, 16'hF000, 16'h1000, 32'd3, 16'd1, 8'd2);
        checkOutput("busy_before_edge", {31'd0, busy}, 32'd0);
        @(negedge clk);
        checkOutput("busy_high", {31'd0, busy}, 32'd1);
        checkOutput("delay_wave", {16'd0, wave_out}, 32'h0055);
        waitStart(cyc);
        checkOutput("first_start_lat", cyc, 32'd6);
        waitDone();
        stopRun();

        // Saw down: first sample 0100 + 2*FF = 02FE
        for (int k = 0; k < 15; k++) pushSample(16'h0100 + 16'(2 * (8'hFF - k * 16)), k == 0);
        applyStimulus(2'b01, 16'hF000, 16'h1000, 32'd3, 16'd1, 8'd2);
        waitDone();
        stopRun();

        // Triangle: w = 00,40,80,C0,FF,BF,7F,3F
        pushSample(16'h0100, 1'b1);
        pushSample(16'h0180, 1'b0);
        pushSample(16'h0200, 1'b0);
        pushSample(16'h0280, 1'b0);
        pushSample(16'h02FE, 1'b0);
        pushSample(16'h027E, 1'b0);
        pushSample(16'h01FE, 1'b0);
        pushSample(16'h017E, 1'b0);
        applyStimulus(2'b10, 16'hFFFF, 16'h2000, 32'd3, 16'd1, 8'd2);
        waitDone();
        stopRun();

        // Burst of 3 short ramps: 0100,0180,0200,0280 each
        for (int r = 0; r < 3; r++) begin
            pushSample(16'h0100, 1'b1);
            pushSample(16'h0180, 1'b0);
            pushSample(16'h0200, 1'b0);
            pushSample(16'h0280, 1'b0);
        end
        applyStimulus(2'b11, 16'hF000, 16'h4000, 32'd3, 16'd3, 8'd2);
        waitDone();
        stopRun();

        // Continuous: 10 ramps, never done
        for (int r = 0; r < 10; r++) begin
            pushSample(16'h0100, 1'b1);
            pushSample(16'h0180, 1'b0);
            pushSample(16'h0200, 1'b0);
            pushSample(16'h0280, 1'b0);
        end
        applyStimulus(2'b00, 16'hF000, 16'h4000, 32'd3, 16'd0, 8'd2);
        for (int r = 0; r < 10; r++) waitStart(cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (ramp_active && cyc < 50);
        checkOutput("cont_ramp_end", {31'd0, ramp_active}, 32'd0);
        checkOutput("cont_no_done", {31'd0, burst_done}, 32'd0);
        stopRun();

        // Shadowing: amp changes mid-ramp, applies from the next ramp
        for (int k = 0; k < 15; k++) pushSample(16'h0100 + 16'(k * 16'h20), k == 0);
        for (int k = 0; k < 15; k++) pushSample(16'h0100 + 16'(k * 16'h40), k == 0);
        applyStimulus(2'b00, 16'hF000, 16'h1000, 32'd3, 16'd2, 8'd2);
        waitStart(cyc);
        amp = 8'd4;
        waitDone();
        stopRun();

        // One-sample ramps with a single DELAY cycle
        pushSample(16'h0100, 1'b1);
        pushSample(16'h0100, 1'b1);
        applyStimulus(2'b00, 16'hF000, 16'hF000, 32'd0, 16'd2, 8'd2);
        waitStart(cyc);
        checkOutput("dly0_first_lat", cyc, 32'd4);
        waitStart(cyc);
        checkOutput("dly0_start_gap", cyc, 32'd2);
        waitDone();
        stopRun();

        // out_en dropped mid-ramp: samples 0..2 drain, then DC
        pushSample(16'h0100, 1'b1);
        pushSample(16'h0120, 1'b0);
        pushSample(16'h0140, 1'b0);
        applyStimulus(2'b00, 16'hF000, 16'h1000, 32'd3, 16'd1, 8'd2);
        waitStart(cyc);
        out_en = 1'b0;
        @(negedge clk);
        checkOutput("drop_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("drop_wave", {16'd0, wave_out}, 32'h0055);
        checkOutput("drop_queue", exp_q.size(), 32'd0);

        // Reset mid-ramp, then restart with a full DELAY
        pushSample(16'h0100, 1'b1);
        applyStimulus(2'b00, 16'hF000, 16'h1000, 32'd3, 16'd1, 8'd2);
        waitStart(cyc);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_wave", {16'd0, wave_out}, 32'd0);
        checkOutput("mid_rst_active", {31'd0, ramp_active}, 32'd0);
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("mid_rst_queue", exp_q.size(), 32'd0);
        for (int k = 0; k < 15; k++) pushSample(16'h0100 + 16'(k * 16'h20), k == 0);
        rst = 1'b0;
        waitStart(cyc);
        checkOutput("restart_lat", cyc, 32'd7);
        waitDone();
        stopRun();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
